// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared types and helpers for the SPI transaction sequencer.
// Contents: FSM state encoding, reset defaults for the SPI core config
// outputs, and a length clamp helper used when latching wr_len/rd_len.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_WAIT,
    S_RD_ACK,
    S_RD_CAP,
    S_FIN
  } state_t;

  localparam logic [1:0] SPIBR_DEFAULT = 2'b00;
  localparam logic [2:0] SPICR_DEFAULT = 3'b000;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/spi_seq_buf.sv
// spi_seq_buf: byte register file with one synchronous write port and one
// combinational read port. Writes to addresses >= DEPTH are dropped and
// reads from them return 0. Contents are not reset.
// Ports:
//   clk          system clock
//   we/waddr/wdata  synchronous write port
//   raddr/rdata     combinational read port
module spi_seq_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // Storage is rounded up to a power of two so the index is exactly IW bits;
  // the range checks below keep the spare entries unreachable.
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem [2**IW];

  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(DEPTH))) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (raddr < AW'(DEPTH)) begin
      rdata = mem[raddr[IW-1:0]];
    end
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: SPI transaction sequencer in front of the byte-level SPI core.
// Streams wr_len command bytes from the command buffer to the core, then
// collects rd_len response bytes into the readback buffer, with a per-byte
// timeout on spi_ready_to_read.
// Ports:
//   clk, reset (sync, active-low)
//   start, wr_len, rd_len, cfg_spibr, cfg_spicr  transaction request
//   cmd_we, cmd_addr, cmd_wdata                  command buffer load
//   rsp_addr, rsp_rdata                          readback buffer read
//   busy, done, err, rd_count                    status
//   spibr, spicr, spi_data_in, spi_write_byte,
//   spi_read_byte, spi_data_out, spi_ready_to_read  SPI core interface
import spi_seq_pkg::*;

module spi_xfer_seq #(
  parameter int unsigned MAX_WR      = 8,
  parameter int unsigned MAX_RD      = 8,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned WA          = $clog2(MAX_WR + 1),
  parameter int unsigned RA          = $clog2(MAX_RD + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [WA-1:0] wr_len,
  input  logic [RA-1:0] rd_len,
  input  logic [1:0]    cfg_spibr,
  input  logic [2:0]    cfg_spicr,
  input  logic          cmd_we,
  input  logic [WA-1:0] cmd_addr,
  input  logic [7:0]    cmd_wdata,
  input  logic [RA-1:0] rsp_addr,
  output logic [7:0]    rsp_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [RA-1:0] rd_count,
  output logic [1:0]    spibr,
  output logic [2:0]    spicr,
  output logic [7:0]    spi_data_in,
  output logic          spi_write_byte,
  output logic          spi_read_byte,
  input  logic [7:0]    spi_data_out,
  input  logic          spi_ready_to_read
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state, state_nx;
  logic [WA-1:0] wr_len_q, wr_len_nx, wr_idx, wr_idx_nx, wr_clamp;
  logic [RA-1:0] rd_len_q, rd_len_nx, rd_count_nx, rd_clamp;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          busy_nx, done_nx, err_nx, wstb_nx, rstb_nx;
  logic [1:0]    spibr_nx;
  logic [2:0]    spicr_nx;
  logic [7:0]    data_in_nx, cmd_rdata;

  assign wr_clamp = WA'(clamp_len(32'(wr_len), MAX_WR));
  assign rd_clamp = RA'(clamp_len(32'(rd_len), MAX_RD));

  // Command buffer is frozen outside IDLE; it is read at the send index.
  spi_seq_buf #(.DEPTH(MAX_WR), .AW(WA)) u_cmd_buf (
    .clk   (clk),
    .we    (cmd_we && (state == S_IDLE)),
    .waddr (cmd_addr),
    .wdata (cmd_wdata),
    .raddr (wr_idx),
    .rdata (cmd_rdata)
  );

  spi_seq_buf #(.DEPTH(MAX_RD), .AW(RA)) u_rsp_buf (
    .clk   (clk),
    .we    (state == S_RD_CAP),
    .waddr (rd_count),
    .wdata (spi_data_out),
    .raddr (rsp_addr),
    .rdata (rsp_rdata)
  );

  // All SPI-facing outputs are registered: the comb block computes their
  // next values alongside the next state.
  always_comb begin
    state_nx    = state;
    wr_len_nx   = wr_len_q;
    rd_len_nx   = rd_len_q;
    wr_idx_nx   = wr_idx;
    rd_count_nx = rd_count;
    tcnt_nx     = tcnt;
    busy_nx     = busy;
    done_nx     = 1'b0;
    err_nx      = err;
    wstb_nx     = 1'b0;
    rstb_nx     = 1'b0;
    spibr_nx    = spibr;
    spicr_nx    = spicr;
    data_in_nx  = spi_data_in;
    case (state)
      S_IDLE: begin
        if (start) begin
          wr_len_nx   = wr_clamp;
          rd_len_nx   = rd_clamp;
          spibr_nx    = cfg_spibr;
          spicr_nx    = cfg_spicr;
          err_nx      = 1'b0;
          rd_count_nx = '0;
          wr_idx_nx   = '0;
          tcnt_nx     = '0;
          busy_nx     = 1'b1;
          if (wr_clamp != '0)      state_nx = S_WR;
          else if (rd_clamp != '0) state_nx = S_RD_WAIT;
          else                     state_nx = S_FIN;
        end
      end
      S_WR: begin
        wstb_nx    = 1'b1;
        data_in_nx = cmd_rdata;
        if (wr_idx == wr_len_q - WA'(1)) begin
          state_nx = (rd_len_q != '0) ? S_RD_WAIT : S_FIN;
        end else begin
          wr_idx_nx = wr_idx + WA'(1);
        end
      end
      S_RD_WAIT: begin
        if (spi_ready_to_read) begin
          rstb_nx  = 1'b1;
          state_nx = S_RD_ACK;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          err_nx   = 1'b1;
          state_nx = S_FIN;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      S_RD_ACK: state_nx = S_RD_CAP;
      S_RD_CAP: begin
        rd_count_nx = rd_count + RA'(1);
        tcnt_nx     = '0;
        state_nx    = (rd_count_nx < rd_len_q) ? S_RD_WAIT : S_FIN;
      end
      S_FIN: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      wr_len_q       <= '0;
      rd_len_q       <= '0;
      wr_idx         <= '0;
      rd_count       <= '0;
      tcnt           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      spi_write_byte <= 1'b0;
      spi_read_byte  <= 1'b0;
      spibr          <= SPIBR_DEFAULT;
      spicr          <= SPICR_DEFAULT;
      spi_data_in    <= '0;
    end else begin
      state          <= state_nx;
      wr_len_q       <= wr_len_nx;
      rd_len_q       <= rd_len_nx;
      wr_idx         <= wr_idx_nx;
      rd_count       <= rd_count_nx;
      tcnt           <= tcnt_nx;
      busy           <= busy_nx;
      done           <= done_nx;
      err            <= err_nx;
      spi_write_byte <= wstb_nx;
      spi_read_byte  <= rstb_nx;
      spibr          <= spibr_nx;
      spicr          <= spicr_nx;
      spi_data_in    <= data_in_nx;
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: self-checking bench for spi_xfer_seq.
// A timeline model derives, per transaction, the expected value of every
// status/SPI output at each cycle after start, from the lengths, the
// command image and the ready_to_read schedule; one compare process checks
// the DUT against it every cycle. Literal checks pin key numbers.
module tb_spi_xfer_seq;

  localparam int MAX_WR = 8;
  localparam int MAX_RD = 8;
  localparam int TMO    = 16;
  localparam int NT     = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] wr_len = '0, rd_len = '0, cmd_addr = '0, rsp_addr = '0;
  logic [1:0] cfg_spibr = '0;
  logic [2:0] cfg_spicr = '0;
  logic       cmd_we = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic [7:0] rsp_rdata, spi_data_in;
  logic       busy, done, err, spi_write_byte, spi_read_byte;
  logic [3:0] rd_count;
  logic [1:0] spibr;
  logic [2:0] spicr;
  logic [7:0] spi_data_out = '0;
  logic       spi_ready_to_read = 1'b0;

  spi_xfer_seq #(.MAX_WR(MAX_WR), .MAX_RD(MAX_RD), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_len(wr_len), .rd_len(rd_len),
    .cfg_spibr(cfg_spibr), .cfg_spicr(cfg_spicr), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .busy(busy), .done(done), .err(err),
    .rd_count(rd_count), .spibr(spibr), .spicr(spicr),
    .spi_data_in(spi_data_in), .spi_write_byte(spi_write_byte),
    .spi_read_byte(spi_read_byte), .spi_data_out(spi_data_out),
    .spi_ready_to_read(spi_ready_to_read)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  int cyc = 0, t0 = 0, end_rel = 0;
  bit chk_on = 1'b0;
  int n_wr, n_rd, n_done, done_rel;

  // Model state
  bit         ready_sched [NT];
  logic [7:0] miso [8];
  logic [7:0] cmd_img [8];
  bit         exp_busy [NT], exp_done [NT], exp_wr [NT], exp_rd [NT], exp_err [NT];
  logic [7:0] exp_wdata [NT];
  int         exp_cnt [NT];
  logic [1:0] exp_br [NT];
  logic [2:0] exp_cr [NT];
  int         m_cnt = 0;
  bit         m_err = 1'b0;
  logic [1:0] m_br = '0;
  logic [2:0] m_cr = '0;
  int         m_ncap;
  bit         m_tmo;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPI core stand-in: ready follows the schedule; each read strobe
  // presents the next response byte.
  int mi = 0;
  int rel_d;
  always @(posedge clk) begin
    #2;
    rel_d = cyc - t0;
    if (chk_on && rel_d < NT) begin
      if (rel_d == 0) mi = 0;
      spi_ready_to_read = ready_sched[rel_d];
      if (spi_read_byte) begin
        spi_data_out = miso[mi];
        if (mi < 7) mi++;
      end
    end else begin
      spi_ready_to_read = 1'b0;
    end
  end

  // Timeline model: relative cycle 0 is the cycle start is presented.
  function automatic void build_model(input int w, input int r,
                                      input logic [1:0] br, input logic [2:0] cr);
    int wc, rc, t, waited, fin;
    int cap_vis [8];
    wc = (w > MAX_WR) ? MAX_WR : w;
    rc = (r > MAX_RD) ? MAX_RD : r;
    for (int i = 0; i < NT; i++) begin
      exp_busy[i] = 0; exp_done[i] = 0; exp_wr[i] = 0; exp_rd[i] = 0;
      exp_err[i] = 0; exp_wdata[i] = '0; exp_cnt[i] = 0;
      exp_br[i] = br; exp_cr[i] = cr;
    end
    for (int i = 0; i < wc; i++) begin
      exp_wr[2 + i] = 1; exp_wdata[2 + i] = cmd_img[i];
    end
    t = 1 + wc; m_ncap = 0; m_tmo = 0;
    for (int k = 0; k < rc && !m_tmo; k++) begin
      waited = 0;
      while (!ready_sched[t] && waited < TMO) begin t++; waited++; end
      if (waited == TMO) m_tmo = 1;
      else begin
        exp_rd[t + 1] = 1;
        cap_vis[m_ncap] = t + 3;
        m_ncap++;
        t += 3;
      end
    end
    fin = t;
    end_rel = fin + 2;
    for (int i = 1; i <= end_rel; i++) begin
      exp_busy[i] = (i <= fin);
      exp_err[i]  = m_tmo && (i >= fin);
      for (int c = 0; c < m_ncap; c++) if (cap_vis[c] <= i) exp_cnt[i]++;
    end
    exp_done[fin + 1] = 1;
    exp_cnt[0] = m_cnt; exp_err[0] = m_err; exp_br[0] = m_br; exp_cr[0] = m_cr;
  endfunction

  int rel_c;
  always @(negedge clk) begin
    rel_c = cyc - t0;
    if (chk_on && rel_c <= end_rel) begin
      check("busy", busy, exp_busy[rel_c]);
      check("done", done, exp_done[rel_c]);
      check("write_byte", spi_write_byte, exp_wr[rel_c]);
      if (exp_wr[rel_c]) check("data_in", spi_data_in, exp_wdata[rel_c]);
      check("read_byte", spi_read_byte, exp_rd[rel_c]);
      check("rd_count", rd_count, exp_cnt[rel_c]);
      check("err", err, exp_err[rel_c]);
      check("spibr", spibr, exp_br[rel_c]);
      check("spicr", spicr, exp_cr[rel_c]);
      if (spi_write_byte) n_wr++;
      if (spi_read_byte) n_rd++;
      if (done) begin n_done++; done_rel = rel_c; end
    end
  end

  task automatic run_txn(input int w, input int r, input logic [1:0] br,
                         input logic [2:0] cr, input bit inject);
    logic [7:0] wl, rl;
    build_model(w, r, br, cr);
    wl = 8'(w); rl = 8'(r);
    @(posedge clk); #1;
    t0 = cyc; n_wr = 0; n_rd = 0; n_done = 0; done_rel = -1;
    wr_len = wl[3:0]; rd_len = rl[3:0]; cfg_spibr = br; cfg_spicr = cr;
    start = 1'b1; chk_on = 1'b1;
    for (int i = 1; i <= end_rel; i++) begin
      @(posedge clk); #1;
      start = 1'b0; cmd_we = 1'b0;
      if (inject && i == 3) begin
        start = 1'b1; wr_len = 4'd1; rd_len = 4'd0;
        cfg_spibr = ~br; cfg_spicr = ~cr;
        cmd_we = 1'b1; cmd_addr = 4'd1; cmd_wdata = 8'h00;
      end
    end
    @(posedge clk); #1;
    chk_on = 1'b0;
    m_cnt = m_ncap; m_err = m_tmo; m_br = br; m_cr = cr;
  endtask

  task automatic load_cmd(input int a, input logic [7:0] d);
    @(posedge clk); #1;
    cmd_we = 1'b1; cmd_addr = 4'(a); cmd_wdata = d; cmd_img[a] = d;
    @(posedge clk); #1;
    cmd_we = 1'b0;
  endtask

  task automatic chk_rsp(input int a, input logic [7:0] e);
    rsp_addr = 4'(a); #1;
    check("rsp_rdata", rsp_rdata, e);
  endtask

  initial begin
    logic [7:0] cmd_init [8];
    int nd;
    cmd_init = '{8'h9F, 8'h76, 8'hF2, 8'h73, 8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_err", err, 0); check("rst_wstb", spi_write_byte, 0);
    check("rst_rstb", spi_read_byte, 0); check("rst_spibr", spibr, 0);
    check("rst_spicr", spicr, 0); check("rst_data_in", spi_data_in, 0);
    check("rst_rd_count", rd_count, 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) load_cmd(i, cmd_init[i]);
    chk_rsp(9, 8'h00);

    // Main transfer
    for (int i = 0; i < NT; i++) ready_sched[i] = 1;
    miso = '{8'hEF, 8'h40, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(4, 4, 2'b10, 3'b011, 0);
    check("t1_nwr", n_wr, 4); check("t1_ndone", n_done, 1);
    check("t1_done_rel", done_rel, 18); check("t1_rd_count", rd_count, 4);
    check("t1_err", err, 0);
    chk_rsp(0, 8'hEF); chk_rsp(1, 8'h40); chk_rsp(2, 8'h18); chk_rsp(3, 8'h00);

    // Empty transaction
    run_txn(0, 0, 2'b01, 3'b100, 0);
    check("t2_done_rel", done_rel, 2); check("t2_nwr", n_wr, 0);
    check("t2_nrd", n_rd, 0);
    chk_rsp(2, 8'h18);

    // Timeout on second byte
    for (int i = 0; i < NT; i++) ready_sched[i] = 0;
    ready_sched[1] = 1;
    miso[0] = 8'hA5;
    run_txn(0, 2, 2'b11, 3'b111, 0);
    check("t3_err", err, 1); check("t3_rd_count", rd_count, 1);
    check("t3_done_rel", done_rel, 21); check("t3_ndone", n_done, 1);
    chk_rsp(0, 8'hA5);

    // start/cmd_we while busy are ignored
    for (int i = 0; i < NT; i++) ready_sched[i] = 1;
    miso[0] = 8'h5A;
    run_txn(4, 1, 2'b01, 3'b010, 1);
    check("t4_nwr", n_wr, 4); check("t4_ndone", n_done, 1);
    run_txn(2, 0, 2'b00, 3'b001, 0);
    check("t4_nwr2", n_wr, 2);

    // Over-length clamp
    run_txn(MAX_WR + 3, 0, 2'b10, 3'b110, 0);
    check("t5_nwr", n_wr, MAX_WR); check("t5_done_rel", done_rel, 10);

    // Reset during RD_WAIT
    @(posedge clk); #1;
    wr_len = 4'd0; rd_len = 4'd2; cfg_spibr = 2'b11; cfg_spicr = 3'b101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_busy_pre", busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("t6_busy", busy, 0); check("t6_done", done, 0);
    check("t6_err", err, 0); check("t6_wstb", spi_write_byte, 0);
    check("t6_rstb", spi_read_byte, 0); check("t6_spibr", spibr, 0);
    check("t6_spicr", spicr, 0); check("t6_data_in", spi_data_in, 0);
    check("t6_rd_count", rd_count, 0);
    nd = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("t6_no_done", nd, 0);
    m_cnt = 0; m_err = 0; m_br = '0; m_cr = '0;
    miso[0] = 8'hC3;
    run_txn(2, 1, 2'b01, 3'b011, 0);
    check("t6_ndone", n_done, 1); check("t6_done_rel", done_rel, 7);
    chk_rsp(0, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
